ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port arbiter sharing the single-ported rambus between the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Sits between the core's fetch/LSU interfaces and rambus.
- Issues at most one RAM access per cycle, with round-robin fairness, a D-side lock for atomic read-modify-write, and range checking.
- Returns registered responses one cycle after grant.

Parameters:
- BASE_ADDR, RAM_BASE_ADDR (typepkg): first valid byte address.
- END_ADDR, RAM_END_ADDR (typepkg): first invalid byte address (exclusive).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- i_req  input  1  fetch request valid
- i_addr  input  32  fetch byte address
- i_gnt  output  1  fetch request accepted this cycle
- i_rvalid  output  1  fetch response valid (1-cycle pulse)
- i_rdata  output  32  fetch read data
- i_err  output  1  fetch response error (qualifies i_rvalid)
- d_req  input  1  data request valid
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data byte address
- d_wdata  input  32  write data
- d_wstrb  input  4  byte write strobes
- d_lock  input  1  keep bus ownership after this D access
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  data response valid (1-cycle pulse)
- d_rdata  output  32  data read data (0 on writes)
- d_err  output  1  data response error
- ram_addr  output  32  to rambus addr
- ram_wdata  output  32  to rambus wdata
- ram_re  output  1  to rambus re
- ram_we  output  1  to rambus we
- ram_wstrb  output  4  to rambus wstrb
- ram_rdata  input  32  from rambus rdata (combinational read)

Behaviour:
- Request/grant handshake:
  - Requester holds req, addr and all payload stable until gnt=1.
  - Transfer occurs in the cycle where req&&gnt.
  - gnt is combinational from req and state; gnt never asserts without req.
  - At most one of i_gnt/d_gnt is high per cycle.
- State:
  - last (0=I, 1=D): owner of the most recent grant.
  - locked: set when a D transfer has d_lock=1.
  - Response registers: per port rvalid, rdata, err.
- Arbitration when not locked:
  - Only one req high: grant it.
  - Both high: grant the port that is not last.
  - Update last on every grant.
- Lock:
  - While locked=1, i_gnt=0; d_gnt=d_req.
  - locked clears on a D transfer with d_lock=0.
  - locked holds when d_req=0; an idle D side keeps the lock.
- Range check:
  - in_range = addr>=BASE_ADDR && addr<END_ADDR && addr[1:0]==0.
  - Out-of-range I/D requests are still granted, but ram_re=ram_we=0 that cycle.
  - Next cycle: err=1, rdata=0.
  - Sub-word alignment is the LSU's job via wstrb; D addresses are word addresses with [1:0]=0.
- RAM drive, in grant cycle, for an in-range request:
  - ram_addr = granted addr.
  - ram_re = ~we.
  - ram_we = d_we (D only).
  - ram_wstrb and ram_wdata from D.
- RAM drive otherwise: ram_re=ram_we=0, ram_wstrb=0, ram_addr/ram_wdata=0.
- Latency:
  - Read data is sampled from ram_rdata at the end of the grant cycle.
  - x_rvalid=1 exactly one cycle after the transfer, with the registered rdata/err.
  - Writes also produce d_rvalid (ack) with d_rdata=0.
  - Back-to-back grants yield back-to-back rvalid pulses.
- Throughput: one transfer per cycle, sustained; no bubbles.
- Reset (rst=1 at posedge):
  - last=1, so I wins the first tie.
  - locked=0.
  - All rvalid/err=0, rdata=0.
  - A transfer granted in the reset cycle produces no response.
  - Combinational outputs are forced 0 while rst=1: gnt, ram_re, ram_we.

Test Plan:
- Reset, then i_req=1 with i_addr=BASE_ADDR+0x10 (mem word=0xDEADBEEF) -> i_gnt=1 same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0; no d_rvalid.
- Both req held 4 cycles (I addrs +0,+4; D reads) -> grants I,D,I,D; four rvalid pulses alternating; rdata matches the preloaded words.
- D write d_addr=BASE+0x20, d_wdata=0x11223344, d_wstrb=4'b0101 on a word holding 0xAABBCCDD -> ram_we=1 one cycle; next cycle d_rvalid=1, d_rdata=0; subsequent read returns 0xAA22CC44.
- D read with d_lock=1, then 2 idle D cycles with i_req=1 throughout, then D write with d_lock=0 -> i_gnt=0 until the cycle after the unlocking write; then i_gnt=1.
- i_addr=END_ADDR and d_addr=BASE+0x2 -> both granted (in turn), ram_re=ram_we=0; responses err=1, rdata=0; RAM contents unchanged.
- rst asserted in a cycle where d_req&&d_gnt would occur and locked=1 -> no d_rvalid the next cycle; locked=0 after reset; a tie then grants I first.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing a single-ported RAM between instruction fetch (I)
// and load/store (D), with round-robin ties, D-side lock and range checking.
module ram_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] END_ADDR  = 32'h0000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_lock,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata
);

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a < END_ADDR) && (a[1:0] == 2'b00);
  endfunction

  logic last;    // owner of the most recent grant: 0 = I, 1 = D
  logic locked;
  logic i_ok;
  logic d_ok;

  assign i_ok = in_range(i_addr);
  assign d_ok = in_range(d_addr);

  // Grant selection; a tie goes to whichever port did not win last time.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (locked) begin
        d_gnt = d_req;
      end else if (i_req && d_req) begin
        i_gnt = last;
        d_gnt = ~last;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // RAM drive for the granted, in-range request; idle bus otherwise.
  always_comb begin
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wstrb = 4'h0;
    if (d_gnt && d_ok) begin
      ram_addr  = d_addr;
      ram_wdata = d_wdata;
      ram_wstrb = d_wstrb;
      ram_re    = ~d_we;
      ram_we    = d_we;
    end else if (i_gnt && i_ok) begin
      ram_addr = i_addr;
      ram_re   = 1'b1;
    end
  end

  // Arbitration state and one-cycle registered responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      locked   <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= 32'h0;
      i_err    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0;
      d_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      i_err    <= i_gnt && !i_ok;
      i_rdata  <= (i_gnt && i_ok) ? ram_rdata : 32'h0;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt && !d_ok;
      d_rdata  <= (d_gnt && d_ok && !d_we) ? ram_rdata : 32'h0;
      if (i_gnt) begin
        last <= 1'b0;
      end
      if (d_gnt) begin
        last   <= 1'b1;
        locked <= d_lock;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run against a behavioural model with its own copy of memory.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ENDA = 32'h0000_1100;
  localparam int unsigned NW = 64;

  logic        clk, rst;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wstrb;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_re, ram_we;
  logic [3:0]  ram_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram  [0:NW-1];
  logic [31:0] gold [0:NW-1];
  logic        preload;
  int          we_count;

  ram_arbiter #(.BASE_ADDR(BASE), .END_ADDR(ENDA)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re),
    .ram_we(ram_we), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 8) return 32'hAABB_CCDD;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic ok(input logic [31:0] a);
    return (a >= BASE) && (a < ENDA) && (a % 4 == 0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Rambus model: combinational read, byte-strobed write at the clock edge.
  assign ram_rdata = (ram_addr >= BASE && ram_addr < ENDA) ? ram[widx(ram_addr)] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(NW); i++) ram[i] <= pat(i);
      we_count <= 0;
    end else if (ram_we) begin
      we_count <= we_count + 1;
      if (ram_addr >= BASE && ram_addr < ENDA)
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) ram[widx(ram_addr)][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    d_wstrb = 4'h0; d_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    i_req = 1'b1; i_addr = BASE; d_req = 1'b1; d_we = 1'b1; d_addr = BASE;
    d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
    #1;
    n_checks++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_i_gnt: got %b want 0", i_gnt); end
    n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_d_gnt: got %b want 0", d_gnt); end
    n_checks++; if ({ram_re, ram_we} !== 2'b00) begin n_fail++; $display("FAIL rst_ram_ctl: got %b want 00", {ram_re, ram_we}); end
    @(posedge clk); #1;
    n_checks++; if ({i_rvalid, i_err, d_rvalid, d_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_resp_flags: got %b want 0000", {i_rvalid, i_err, d_rvalid, d_err}); end
    n_checks++; if ({i_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {i_rdata, d_rdata}); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    i_req = 1'b1; i_addr = BASE + 32'h10;
    #1;
    n_checks++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got %b want 10", {i_gnt, d_gnt}); end
    n_checks++; if (ram_re !== 1'b1 || ram_addr !== BASE + 32'h10) begin n_fail++; $display("FAIL fetch_ram: got re=%b addr=%h want re=1 addr=%h", ram_re, ram_addr, BASE + 32'h10); end
    @(posedge clk); #1;
    n_checks++; if ({i_rvalid, i_err, d_rvalid} !== 3'b100) begin n_fail++; $display("FAIL fetch_resp: got rv/err/drv=%b want 100", {i_rvalid, i_err, d_rvalid}); end
    n_checks++; if (i_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", i_rdata); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    n_checks++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got %b want 0", i_rvalid); end
  endtask

  task automatic test_back_to_back();
    int ic = 0;
    int dc = 0;
    logic exp_i;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = BASE + 32'(4 * ic);
      d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h30 + 32'(4 * dc);
      exp_i = (k % 2 == 0);
      #1;
      n_checks++; if ({i_gnt, d_gnt} !== {exp_i, !exp_i}) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, {i_gnt, d_gnt}, {exp_i, !exp_i}); end
      @(posedge clk); #1;
      n_checks++; if ({i_rvalid, d_rvalid} !== {exp_i, !exp_i}) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", k, {i_rvalid, d_rvalid}, {exp_i, !exp_i}); end
      if (exp_i) begin
        n_checks++; if (i_rdata !== pat(ic)) begin n_fail++; $display("FAIL b2b_i_rdata[%0d]: got %h want %h", k, i_rdata, pat(ic)); end
        ic++;
      end else begin
        n_checks++; if (d_rdata !== pat(12 + dc)) begin n_fail++; $display("FAIL b2b_d_rdata[%0d]: got %h want %h", k, d_rdata, pat(12 + dc)); end
        dc++;
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_write();
    int wc0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h20; d_wdata = 32'h1122_3344; d_wstrb = 4'b0101;
    wc0 = we_count;
    #1;
    n_checks++; if ({d_gnt, ram_we, ram_re} !== 3'b110) begin n_fail++; $display("FAIL wr_ctl: got gnt/we/re=%b want 110", {d_gnt, ram_we, ram_re}); end
    n_checks++; if (ram_wstrb !== 4'b0101) begin n_fail++; $display("FAIL wr_strb: got %b want 0101", ram_wstrb); end
    @(posedge clk); #1;
    n_checks++; if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_ack: got rv/err=%b rdata=%h want 10/0", {d_rvalid, d_err}, d_rdata); end
    @(negedge clk);
    d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
    #1;
    n_checks++; if (we_count - wc0 !== 1) begin n_fail++; $display("FAIL wr_once: got %0d write cycles want 1", we_count - wc0); end
    @(posedge clk); #1;
    n_checks++; if (d_rdata !== 32'hAA22_CC44) begin n_fail++; $display("FAIL wr_readback: got %h want aa22cc44", d_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock();
    @(negedge clk);
    i_req = 1'b1; i_addr = BASE;
    #1;
    n_checks++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_pre_gnt: got %b want 1", i_gnt); end
    @(negedge clk);
    i_addr = BASE + 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'h28; d_lock = 1'b1;
    #1;
    n_checks++; if ({i_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_take: got %b want 01", {i_gnt, d_gnt}); end
    @(posedge clk); #1;
    n_checks++; if (d_rvalid !== 1'b1 || d_rdata !== pat(10)) begin n_fail++; $display("FAIL lock_read: got rv=%b rdata=%h want 1/%h", d_rvalid, d_rdata, pat(10)); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d_req = 1'b0; d_lock = 1'b0;
      #1;
      n_checks++; if (i_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_hold[%0d]: got i_gnt=%b want 0", k, i_gnt); end
    end
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = BASE + 32'h24; d_wdata = 32'h0BAD_F00D; d_wstrb = 4'hF; d_lock = 1'b0;
    #1;
    n_checks++; if ({i_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_release_gnt: got %b want 01", {i_gnt, d_gnt}); end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; d_wstrb = 4'h0;
    #1;
    n_checks++; if (i_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_after: got i_gnt=%b want 1", i_gnt); end
    @(posedge clk); #1;
    n_checks++; if (i_rvalid !== 1'b1 || i_rdata !== pat(1)) begin n_fail++; $display("FAIL lock_i_resp: got rv=%b rdata=%h want 1/%h", i_rvalid, i_rdata, pat(1)); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_range();
    int wc0;
    logic ig = 1'b0;
    logic dg = 1'b0;
    logic gi, gd;
    wc0 = we_count;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_req = !ig; i_addr = ENDA;
      d_req = !dg; d_we = 1'b1; d_addr = BASE + 32'h2; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
      if (ig && dg) break;
      #1;
      gi = i_gnt; gd = d_gnt;
      n_checks++; if ({1'b0, gi} + {1'b0, gd} !== 2'd1) begin n_fail++; $display("FAIL range_gnt[%0d]: got %b want one-hot", k, {gi, gd}); end
      n_checks++; if ({ram_re, ram_we} !== 2'b00) begin n_fail++; $display("FAIL range_ram[%0d]: got re/we=%b want 00", k, {ram_re, ram_we}); end
      @(posedge clk); #1;
      if (gi) begin
        n_checks++; if ({i_rvalid, i_err} !== 2'b11 || i_rdata !== 32'h0) begin n_fail++; $display("FAIL range_i_resp: got rv/err=%b rdata=%h want 11/0", {i_rvalid, i_err}, i_rdata); end
        ig = 1'b1;
      end
      if (gd) begin
        n_checks++; if ({d_rvalid, d_err} !== 2'b11 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL range_d_resp: got rv/err=%b rdata=%h want 11/0", {d_rvalid, d_err}, d_rdata); end
        dg = 1'b1;
      end
    end
    idle_inputs();
    n_checks++; if (!(ig && dg)) begin n_fail++; $display("FAIL range_both: got i=%b d=%b granted want both", ig, dg); end
    n_checks++; if (we_count !== wc0 || ram[0] !== pat(0)) begin n_fail++; $display("FAIL range_ram_unchanged: got writes=%0d word0=%h want 0/%h", we_count - wc0, ram[0], pat(0)); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = BASE; d_lock = 1'b1;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_lock_gnt: got %b want 1", d_gnt); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt_forced: got %b want 0", d_gnt); end
    @(posedge clk); #1;
    n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp: got %b want 0", d_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    i_req = 1'b1; i_addr = BASE + 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = BASE + 32'hC;
    #1;
    n_checks++; if ({i_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL rstmid_tie: got %b want 10", {i_gnt, d_gnt}); end
    @(posedge clk); #1;
    n_checks++; if (i_rdata !== pat(2)) begin n_fail++; $display("FAIL rstmid_i_rdata: got %h want %h", i_rdata, pat(2)); end
    @(negedge clk);
    i_req = 1'b0;
    #1;
    n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_d_after: got %b want 1", d_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return ENDA + 32'(4 * $urandom_range(0, 3));
    if (r == 1) return BASE - 32'h4;
    if (r == 2) return BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(1, 3));
    return BASE + 32'(4 * $urandom_range(0, NW - 1));
  endfunction

  task automatic test_random();
    logic        m_last, m_locked;
    logic        ip, dp, dwe, dlk;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dws;
    logic        egi, egd, ere, ewe;
    logic [31:0] eaddr, eird, edrd;
    do_reset();
    m_last = 1'b1; m_locked = 1'b0;
    for (int i = 0; i < int'(NW); i++) gold[i] = ram[i];
    ip = 1'b0; dp = 1'b0; ia = 32'h0; da = 32'h0; dwe = 1'b0; dwd = 32'h0; dws = 4'h0; dlk = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1; ia = rand_addr();
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; da = rand_addr(); dwe = 1'($urandom_range(0, 1));
        dwd = $urandom; dws = 4'($urandom_range(0, 15)); dlk = ($urandom_range(0, 3) == 0);
      end
      i_req = ip; i_addr = ia;
      d_req = dp; d_addr = da; d_we = dwe; d_wdata = dwd; d_wstrb = dws; d_lock = dlk;
      // A locked bus belongs to D; otherwise a tie goes to the port that did not win last.
      if (m_locked) begin
        egi = 1'b0; egd = dp;
      end else if (ip && dp) begin
        egi = (m_last == 1'b1); egd = !egi;
      end else begin
        egi = ip; egd = dp;
      end
      ere = (egi && ok(ia)) || (egd && ok(da) && !dwe);
      ewe = egd && ok(da) && dwe;
      eaddr = (egd && ok(da)) ? da : ((egi && ok(ia)) ? ia : 32'h0);
      eird = (egi && ok(ia)) ? gold[widx(ia)] : 32'h0;
      edrd = (egd && ok(da) && !dwe) ? gold[widx(da)] : 32'h0;
      #1;
      n_checks++; if ({i_gnt, d_gnt} !== {egi, egd}) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {i_gnt, d_gnt}, {egi, egd}); end
      n_checks++; if ({ram_re, ram_we} !== {ere, ewe} || ram_addr !== eaddr) begin n_fail++; $display("FAIL rnd_ram[%0d]: got re/we=%b addr=%h want %b/%h", n, {ram_re, ram_we}, ram_addr, {ere, ewe}, eaddr); end
      @(posedge clk); #1;
      n_checks++; if ({i_rvalid, i_err} !== {egi, egi && !ok(ia)} || i_rdata !== eird) begin n_fail++; $display("FAIL rnd_i_resp[%0d]: got rv/err=%b rdata=%h want %b/%h", n, {i_rvalid, i_err}, i_rdata, {egi, egi && !ok(ia)}, eird); end
      n_checks++; if ({d_rvalid, d_err} !== {egd, egd && !ok(da)} || d_rdata !== edrd) begin n_fail++; $display("FAIL rnd_d_resp[%0d]: got rv/err=%b rdata=%h want %b/%h", n, {d_rvalid, d_err}, d_rdata, {egd, egd && !ok(da)}, edrd); end
      if (egi) begin
        m_last = 1'b0; ip = 1'b0;
      end
      if (egd) begin
        m_last = 1'b1; m_locked = dlk; dp = 1'b0;
        if (dwe && ok(da))
          for (int b = 0; b < 4; b++)
            if (dws[b]) gold[widx(da)][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_write();
    test_lock();
    test_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
